// File: rtl/alu_chk_pkg.sv
// Shared definitions for the ALU response checker: opcodes, FSM states,
// and the stage-1 verdict record.
package alu_chk_pkg;

  localparam int CNT_W_DEF = 16;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } chk_state_e;

  // Everything needed to commit one verdict one cycle after acceptance
  typedef struct packed {
    logic [31:0] exp;
    logic        exp_zero;
    logic        illegal;
    logic [31:0] got;
    logic        got_zero;
  } verdict_t;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden ALU: recomputes the expected result and zero flag,
// and flags opcodes outside the defined set.
module alu_ref_model
  import alu_chk_pkg::*;
(
  input  logic [31:0] da,
  input  logic [31:0] db,
  input  logic [2:0]  op,
  output logic [31:0] exp,
  output logic        exp_zero,
  output logic        illegal
);

  always_comb begin
    exp     = '0;
    illegal = 1'b0;
    case (op)
      OP_ADD:  exp = da + db;
      OP_SUB:  exp = da - db;
      OP_AND:  exp = da & db;
      OP_OR:   exp = da | db;
      OP_XOR:  exp = da ^ db;
      default: illegal = 1'b1;
    endcase
  end

  assign exp_zero = (exp == 32'd0);

endmodule

// File: rtl/alu_resp_checker.sv
// Run-based ALU response checker: accepts num_ops samples, grades each against
// the golden model one cycle later, tallies verdicts and latches the first fail.
module alu_resp_checker
  import alu_chk_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_ops,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      alu_da,
  input  logic [31:0]      alu_db,
  input  logic [2:0]       alu_op,
  input  logic [31:0]      alu_dc,
  input  logic             alu_zero,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic             err,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [31:0]      first_fail_exp,
  output logic [31:0]      first_fail_got
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  chk_state_e       state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             s1_vld_q, s1_vld_d;
  verdict_t         s1_q, s1_d;
  logic [CNT_W-1:0] s1_idx_q, s1_idx_d;
  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d, ill_q, ill_d;
  logic             err_q, err_d, done_q, done_d;
  logic [CNT_W-1:0] ff_idx_q, ff_idx_d;
  logic [31:0]      ff_exp_q, ff_exp_d, ff_got_q, ff_got_d;

  logic [31:0] ref_exp;
  logic        ref_zero, ref_illegal;

  alu_ref_model u_ref (
    .da       (alu_da),
    .db       (alu_db),
    .op       (alu_op),
    .exp      (ref_exp),
    .exp_zero (ref_zero),
    .illegal  (ref_illegal)
  );

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    acc_d    = acc_q;
    s1_vld_d = 1'b0;
    s1_d     = s1_q;
    s1_idx_d = s1_idx_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    ill_d    = ill_q;
    err_d    = err_q;
    done_d   = 1'b0;
    ff_idx_d = ff_idx_q;
    ff_exp_d = ff_exp_q;
    ff_got_d = ff_got_q;

    // Stage 1 commit; never coincides with a start since IDLE holds no sample
    if (s1_vld_q) begin
      if (s1_q.illegal) begin
        ill_d = sat_inc(ill_q);
      end else if (s1_q.got == s1_q.exp && s1_q.got_zero == s1_q.exp_zero) begin
        pass_d = sat_inc(pass_q);
      end else begin
        fail_d = sat_inc(fail_q);
        if (!err_q) begin
          err_d    = 1'b1;
          ff_idx_d = s1_idx_q;
          ff_exp_d = s1_q.exp;
          ff_got_d = s1_q.got;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          target_d = num_ops;
          acc_d    = '0;
          pass_d   = '0;
          fail_d   = '0;
          ill_d    = '0;
          err_d    = 1'b0;
          ff_idx_d = '0;
          ff_exp_d = '0;
          ff_got_d = '0;
          if (num_ops == '0) done_d = 1'b1;
          else               state_d = RUN;
        end
      end
      RUN: begin
        if (in_valid) begin
          s1_vld_d = 1'b1;
          s1_d     = '{exp: ref_exp, exp_zero: ref_zero, illegal: ref_illegal,
                       got: alu_dc, got_zero: alu_zero};
          s1_idx_d = acc_q;
          acc_d    = acc_q + ONE;
          if (acc_q == target_q - ONE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The final sample is in stage 1 and commits on this edge
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= '0;
      acc_q    <= '0;
      s1_vld_q <= 1'b0;
      s1_q     <= '0;
      s1_idx_q <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      ill_q    <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      ff_idx_q <= '0;
      ff_exp_q <= '0;
      ff_got_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      acc_q    <= acc_d;
      s1_vld_q <= s1_vld_d;
      s1_q     <= s1_d;
      s1_idx_q <= s1_idx_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      ill_q    <= ill_d;
      err_q    <= err_d;
      done_q   <= done_d;
      ff_idx_q <= ff_idx_d;
      ff_exp_q <= ff_exp_d;
      ff_got_q <= ff_got_d;
    end
  end

  assign in_ready       = (state_q == RUN);
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign pass_cnt       = pass_q;
  assign fail_cnt       = fail_q;
  assign illegal_cnt    = ill_q;
  assign err            = err_q;
  assign first_fail_idx = ff_idx_q;
  assign first_fail_exp = ff_exp_q;
  assign first_fail_got = ff_got_q;

endmodule
